mem_arbiter: RTL and testbench

- Sequences the single unified main memory between instruction-cache miss fills and data-cache miss handling (dirty writeback, then fill).
- Sits between the I-cache/D-cache controllers and the multi-cycle memory model.
- Owns the memory latency counter and the grant FSM.
- Provides per-cache fill strobes and an i_stall/d_stall pair that the pipeline ORs with the decode-stage bubble.

---
 rtl/mem_arbiter_pkg.sv | 36 +++
 rtl/mem_lat_counter.sv | 45 ++++
 rtl/mem_arbiter.sv | 158 +++++++++++++++
 tb/tb_mem_arbiter.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_arbiter_pkg
// Shared definitions for the main-memory arbiter and the cache controllers:
//   - default line and line-address widths
//   - grant FSM state encoding (localparams plus the typedef'd enum)
//   - helper to size the memory latency counter
// -----------------------------------------------------------------------------
package mem_arbiter_pkg;

  localparam int LINE_W_DEF = 64;  // 4 x 16-bit words
  localparam int ADDR_W_DEF = 14;  // word address [15:2]

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] D_WB   = 3'd1;
  localparam logic [2:0] D_FILL = 3'd2;
  localparam logic [2:0] I_FILL = 3'd3;
  localparam logic [2:0] DONE   = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE   = IDLE,
    ST_D_WB   = D_WB,
    ST_D_FILL = D_FILL,
    ST_I_FILL = I_FILL,
    ST_DONE   = DONE
  } state_e;

  // Counter width for a 0..lat-1 count; a latency of 1 still needs one bit.
  function automatic int cnt_width(input int lat);
    if (lat > 1) begin
      return $clog2(lat);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/mem_lat_counter.sv
// -----------------------------------------------------------------------------
// mem_lat_counter
// Counts the cycles of one memory access, 0..MEM_LAT-1.
// Ports:
//   clk   - system clock
//   rst   - asynchronous active-high reset, clears the count
//   en    - advance the count this cycle
//   clr   - synchronous clear (wins over en)
//   last  - count is at MEM_LAT-1 (terminal cycle of the access)
// -----------------------------------------------------------------------------
module mem_lat_counter
  import mem_arbiter_pkg::*;
#(
  parameter int MEM_LAT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic last
);

  localparam int CNT_W = cnt_width(MEM_LAT);

  logic [CNT_W-1:0] cnt_r;

  // Access cycle counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (clr) begin
      cnt_r <= '0;
    end else if (en) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Terminal count decode.
  always_comb begin
    last = (cnt_r == CNT_W'(MEM_LAT - 1));
  end

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Shares the single main memory between I-cache miss fills and D-cache miss
// handling (dirty writeback then fill). D-side misses have fixed priority.
// Ports:
//   clk, rst                 - clock, asynchronous active-high reset
//   i_miss, i_addr           - I-cache miss request (level) and line address
//   d_miss, d_dirty, d_addr  - D-cache miss request, victim-dirty flag, address
//   d_wb_addr, d_wb_data     - victim line address and data for writeback
//   mem_re, mem_we           - memory read / write enables (never together)
//   mem_addr, mem_wdata      - memory line address and write data
//   mem_rdata                - memory read data, valid in last access cycle
//   i_fill_we, i_fill_data   - one-cycle I-cache fill strobe and line
//   d_fill_we, d_fill_data   - one-cycle D-cache fill strobe and line
//   i_stall, d_stall         - pipeline stall requests
// -----------------------------------------------------------------------------
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int MEM_LAT = 4,
  parameter int LINE_W  = LINE_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_miss,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              d_miss,
  input  logic              d_dirty,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [ADDR_W-1:0] d_wb_addr,
  input  logic [LINE_W-1:0] d_wb_data,
  output logic              mem_re,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  output logic              i_fill_we,
  output logic [LINE_W-1:0] i_fill_data,
  output logic              d_fill_we,
  output logic [LINE_W-1:0] d_fill_data,
  output logic              i_stall,
  output logic              d_stall
);

  state_e            state_r;
  logic              mem_re_r;
  logic              mem_we_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [LINE_W-1:0] mem_wdata_r;
  logic [ADDR_W-1:0] fill_addr_r;   // D fill address held across the writeback

  logic access_s;
  logic cnt_clr_s;
  logic last_s;

  // Counter runs only while memory is busy; it clears at the end of every
  // access so each state starts from 0 (including D_WB -> D_FILL).
  always_comb begin
    access_s  = mem_re_r | mem_we_r;
    cnt_clr_s = ~access_s | last_s;
  end

  mem_lat_counter #(
    .MEM_LAT(MEM_LAT)
  ) u_lat (
    .clk (clk),
    .rst (rst),
    .en  (access_s),
    .clr (cnt_clr_s),
    .last(last_s)
  );

  // Grant FSM with registered memory strobes, address and write data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      mem_re_r    <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= '0;
      mem_wdata_r <= '0;
      fill_addr_r <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (d_miss && d_dirty) begin
            state_r     <= ST_D_WB;
            mem_we_r    <= 1'b1;
            mem_addr_r  <= d_wb_addr;
            mem_wdata_r <= d_wb_data;
            fill_addr_r <= d_addr;
          end else if (d_miss) begin
            state_r     <= ST_D_FILL;
            mem_re_r    <= 1'b1;
            mem_addr_r  <= d_addr;
            fill_addr_r <= d_addr;
          end else if (i_miss) begin
            state_r    <= ST_I_FILL;
            mem_re_r   <= 1'b1;
            mem_addr_r <= i_addr;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_D_WB: begin
          // Fill follows the writeback with no idle gap.
          if (last_s) begin
            state_r    <= ST_D_FILL;
            mem_we_r   <= 1'b0;
            mem_re_r   <= 1'b1;
            mem_addr_r <= fill_addr_r;
          end
        end
        ST_D_FILL, ST_I_FILL: begin
          if (last_s) begin
            state_r  <= ST_DONE;
            mem_re_r <= 1'b0;
          end
        end
        ST_DONE: begin
          // Idle cycle lets the cache drop its miss before re-arbitration.
          state_r <= ST_IDLE;
        end
        default: begin
          state_r  <= ST_IDLE;
          mem_re_r <= 1'b0;
          mem_we_r <= 1'b0;
        end
      endcase
    end
  end

  // Memory port drive, fill strobes with pass-through data, and stalls.
  always_comb begin
    mem_re    = mem_re_r;
    mem_we    = mem_we_r;
    mem_addr  = mem_addr_r;
    mem_wdata = mem_wdata_r;

    i_fill_we = (state_r == ST_I_FILL) & last_s;
    d_fill_we = (state_r == ST_D_FILL) & last_s;

    if (i_fill_we) begin
      i_fill_data = mem_rdata;
    end else begin
      i_fill_data = '0;
    end
    if (d_fill_we) begin
      d_fill_data = mem_rdata;
    end else begin
      d_fill_data = '0;
    end

    d_stall = d_miss | (state_r == ST_D_WB) | (state_r == ST_D_FILL);
    i_stall = i_miss | (state_r == ST_I_FILL) | d_stall;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Two arbiters (MEM_LAT=4 and MEM_LAT=1) share one stimulus stream. Each is
// compared every cycle against a schedule model: on a grant the model queues
// the per-cycle memory activity of the whole transaction, then replays it.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_miss = 1'b0, d_miss = 1'b0, d_dirty = 1'b0;
  logic [13:0] i_addr = 14'd0, d_addr = 14'd0, d_wb_addr = 14'd0;
  logic [63:0] d_wb_data = 64'd0, mem_rdata = 64'd0;

  logic        re0, we0, ifw0, dfw0, ist0, dst0;
  logic [13:0] addr0;
  logic [63:0] wd0, ifd0, dfd0;
  logic        re1, we1, ifw1, dfw1, ist1, dst1;
  logic [13:0] addr1;
  logic [63:0] wd1, ifd1, dfd1;

  always #5 clk = ~clk;

  mem_arbiter #(.MEM_LAT(4)) dut (
    .clk(clk), .rst(rst), .i_miss(i_miss), .i_addr(i_addr),
    .d_miss(d_miss), .d_dirty(d_dirty), .d_addr(d_addr),
    .d_wb_addr(d_wb_addr), .d_wb_data(d_wb_data),
    .mem_re(re0), .mem_we(we0), .mem_addr(addr0), .mem_wdata(wd0),
    .mem_rdata(mem_rdata), .i_fill_we(ifw0), .i_fill_data(ifd0),
    .d_fill_we(dfw0), .d_fill_data(dfd0), .i_stall(ist0), .d_stall(dst0)
  );

  mem_arbiter #(.MEM_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .i_miss(i_miss), .i_addr(i_addr),
    .d_miss(d_miss), .d_dirty(d_dirty), .d_addr(d_addr),
    .d_wb_addr(d_wb_addr), .d_wb_data(d_wb_data),
    .mem_re(re1), .mem_we(we1), .mem_addr(addr1), .mem_wdata(wd1),
    .mem_rdata(mem_rdata), .i_fill_we(ifw1), .i_fill_data(ifd1),
    .d_fill_we(dfw1), .d_fill_data(dfd1), .i_stall(ist1), .d_stall(dst1)
  );

  // One cycle of expected memory-side behaviour.
  typedef struct packed {
    logic        re;
    logic        we;
    logic [13:0] addr;
    logic [63:0] wdata;
    logic        ifill;
    logic        dfill;
    logic        ibusy;
    logic        dbusy;
    logic        done;
    logic        own_d;
  } rec_t;

  rec_t q0[$];
  rec_t q1[$];
  rec_t cur[2];
  int   lat[2];
  int   n_vec = 0;
  int   n_err = 0;
  int   tk;
  int   ifc[2];
  int   dfc[2];
  int   nfill;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic push(input int k, input rec_t r);
    if (k == 0) q0.push_back(r);
    else        q1.push_back(r);
  endtask

  task automatic model_reset();
    q0.delete();
    q1.delete();
    cur[0] = '0;
    cur[1] = '0;
  endtask

  // Queue the whole transaction granted from the current request inputs.
  task automatic plan(input int k);
    rec_t r;
    int   n = lat[k];
    if (d_miss) begin
      if (d_dirty) begin
        for (int c = 0; c < n; c++) begin
          r = '0; r.we = 1'b1; r.addr = d_wb_addr; r.wdata = d_wb_data; r.dbusy = 1'b1;
          push(k, r);
        end
      end
      for (int c = 0; c < n; c++) begin
        r = '0; r.re = 1'b1; r.addr = d_addr; r.dbusy = 1'b1; r.dfill = (c == n - 1);
        push(k, r);
      end
      r = '0; r.done = 1'b1; r.own_d = 1'b1;
      push(k, r);
    end else if (i_miss) begin
      for (int c = 0; c < n; c++) begin
        r = '0; r.re = 1'b1; r.addr = i_addr; r.ibusy = 1'b1; r.ifill = (c == n - 1);
        push(k, r);
      end
      r = '0; r.done = 1'b1;
      push(k, r);
    end
  endtask

  task automatic pop(input int k);
    if (k == 0) begin
      if (q0.size() > 0) cur[0] = q0.pop_front();
      else               cur[0] = '0;
    end else begin
      if (q1.size() > 0) cur[1] = q1.pop_front();
      else               cur[1] = '0;
    end
  endtask

  // Advance one clock edge of the model.
  task automatic model_step(input int k);
    int sz;
    sz = (k == 0) ? q0.size() : q1.size();
    if (rst) begin
      model_reset();
    end else if (sz > 0) begin
      pop(k);
    end else if (cur[k].done) begin
      cur[k] = '0;
    end else begin
      plan(k);
      pop(k);
    end
  endtask

  task automatic cmp(input int k, input logic re, input logic we, input logic [13:0] addr,
                     input logic [63:0] wd, input logic ifw, input logic [63:0] ifd,
                     input logic dfw, input logic [63:0] dfd, input logic ist, input logic dst);
    rec_t e;
    e = cur[k];
    chk($sformatf("mem_re[%0d]", k), 64'(re), 64'(e.re));
    chk($sformatf("mem_we[%0d]", k), 64'(we), 64'(e.we));
    chk($sformatf("i_fill_we[%0d]", k), 64'(ifw), 64'(e.ifill));
    chk($sformatf("d_fill_we[%0d]", k), 64'(dfw), 64'(e.dfill));
    chk($sformatf("d_stall[%0d]", k), 64'(dst), 64'(d_miss | e.dbusy));
    chk($sformatf("i_stall[%0d]", k), 64'(ist), 64'(i_miss | e.ibusy | d_miss | e.dbusy));
    if (e.re || e.we) chk($sformatf("mem_addr[%0d]", k), 64'(addr), 64'(e.addr));
    if (e.we)         chk($sformatf("mem_wdata[%0d]", k), wd, e.wdata);
    if (e.ifill)      chk($sformatf("i_fill_data[%0d]", k), ifd, mem_rdata);
    if (e.dfill)      chk($sformatf("d_fill_data[%0d]", k), dfd, mem_rdata);
    if (ifw && ifc[k] < 0) ifc[k] = tk;
    if (dfw && dfc[k] < 0) dfc[k] = tk;
    if (k == 0 && (ifw || dfw)) nfill++;
  endtask

  // Inputs are set at the falling edge; check, then step the model on the rising edge.
  task automatic tick();
    #1;
    if (rst) model_reset();
    cmp(0, re0, we0, addr0, wd0, ifw0, ifd0, dfw0, dfd0, ist0, dst0);
    cmp(1, re1, we1, addr1, wd1, ifw1, ifd1, dfw1, dfd1, ist1, dst1);
    @(posedge clk);
    model_step(0);
    model_step(1);
    tk++;
    @(negedge clk);
  endtask

  task automatic begin_test();
    tk     = 0;
    ifc[0] = -1; ifc[1] = -1;
    dfc[0] = -1; dfc[1] = -1;
    nfill  = 0;
  endtask

  task automatic settle();
    i_miss = 1'b0; d_miss = 1'b0; d_dirty = 1'b0;
    repeat (6) tick();
  endtask

  initial begin
    lat[0] = 4;
    lat[1] = 1;
    model_reset();
    begin_test();

    // Reset state
    @(negedge clk);
    #1;
    chk("rst_mem_addr", 64'(addr0), 64'd0);
    chk("rst_mem_wdata", wd0, 64'd0);
    chk("rst_mem_re", 64'(re0), 64'd0);
    rst = 1'b0;
    repeat (2) tick();

    // I-cache miss fill
    begin_test();
    i_miss = 1'b1; i_addr = 14'h0010; mem_rdata = 64'hAAAA_BBBB_CCCC_DDDD;
    repeat (5) tick();
    i_miss = 1'b0;
    repeat (2) tick();
    chk("t1_ifill_cycle", 64'(ifc[0]), 64'd4);
    chk("t1_ifill_cycle_lat1", 64'(ifc[1]), 64'd1);
    settle();

    // Dirty D miss: writeback then fill
    begin_test();
    d_miss = 1'b1; d_dirty = 1'b1; d_wb_addr = 14'h0100;
    d_wb_data = 64'h1234_5678_9ABC_DEF0; d_addr = 14'h0200; mem_rdata = 64'h0F0F_1111_2222_3333;
    repeat (9) tick();
    d_miss = 1'b0; d_dirty = 1'b0;
    tick();
    chk("t2_dfill_cycle", 64'(dfc[0]), 64'd8);
    chk("t2_dfill_cycle_lat1", 64'(dfc[1]), 64'd2);
    settle();

    // Simultaneous clean D miss and I miss: D first, then I
    begin_test();
    d_miss = 1'b1; d_addr = 14'h0055; i_miss = 1'b1; i_addr = 14'h0044;
    mem_rdata = 64'h5555_6666_7777_8888;
    repeat (5) tick();
    d_miss = 1'b0;
    repeat (6) tick();
    i_miss = 1'b0;
    tick();
    chk("t3_dfill_cycle", 64'(dfc[0]), 64'd4);
    chk("t3_ifill_cycle", 64'(ifc[0]), 64'd10);
    settle();

    // D address changes mid-fill; latched address must hold
    begin_test();
    d_miss = 1'b1; d_addr = 14'h0200; mem_rdata = 64'hDEAD_BEEF_0000_0001;
    repeat (2) tick();
    d_addr = 14'h3FFF;
    repeat (3) tick();
    d_miss = 1'b0;
    tick();
    chk("t4_dfill_cycle", 64'(dfc[0]), 64'd4);
    chk("t4_dfill_cycle_lat1", 64'(dfc[1]), 64'd1);
    settle();

    // Reset in the second I_FILL cycle, then re-grant
    begin_test();
    i_miss = 1'b1; i_addr = 14'h0123; mem_rdata = 64'hCAFE_F00D_1234_4321;
    repeat (2) tick();
    rst = 1'b1;
    tick();
    chk("t5_no_fill_before_rst", 64'(nfill), 64'd0);
    rst = 1'b0;
    repeat (5) tick();
    i_miss = 1'b0;
    tick();
    chk("t5_ifill_after_regrant", 64'(ifc[0]), 64'd7);
    settle();

    // Randomized traffic
    begin_test();
    for (int n = 0; n < 2000; n++) begin
      mem_rdata = {$urandom, $urandom};
      rst = ($urandom_range(0, 249) == 0);
      if (cur[0].done && cur[0].own_d) d_miss = 1'b0;
      if (cur[0].done && !cur[0].own_d) i_miss = 1'b0;
      if (!d_miss && $urandom_range(0, 5) == 0) begin
        d_miss    = 1'b1;
        d_dirty   = $urandom_range(0, 1) == 1;
        d_addr    = 14'($urandom);
        d_wb_addr = 14'($urandom);
        d_wb_data = {$urandom, $urandom};
      end else if (d_miss && $urandom_range(0, 39) == 0) begin
        d_miss = 1'b0;
      end
      if (!i_miss && $urandom_range(0, 4) == 0) begin
        i_miss = 1'b1;
        i_addr = 14'($urandom);
      end else if (i_miss && $urandom_range(0, 39) == 0) begin
        i_miss = 1'b0;
      end
      if ($urandom_range(0, 7) == 0) begin
        d_addr    = 14'($urandom);
        i_addr    = 14'($urandom);
        d_wb_addr = 14'($urandom);
        d_wb_data = {$urandom, $urandom};
        d_dirty   = $urandom_range(0, 1) == 1;
      end
      tick();
    end
    rst = 1'b0;
    settle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
